// File: rtl/light_display_if.sv
// Controller-side bundle for the light display: capture strobe, counts,
// controller state and the conversion busy flag.
interface light_display_if;
  logic       load;
  logic [6:0] cnt_g;
  logic [6:0] cnt_r;
  logic [3:0] state_in;
  logic       busy;

  modport master (output load, output cnt_g, output cnt_r, output state_in, input busy);
  modport slave  (input load, input cnt_g, input cnt_r, input state_in, output busy);
endinterface

// File: rtl/light_display.sv
// Traffic-light display back-end: double-dabble BCD conversion of the green/red
// counts, then an eight-digit multiplexed seven-segment scan with optional blink.
module light_display #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic           clk,
  input  logic           off_r,
  light_display_if.slave ctl,
  input  logic           blink,
  output logic [7:0]     SIG_C,
  output logic [7:0]     AN
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]         state;
  logic [2:0]         iter;
  logic [14:0]        g_sh;
  logic [14:0]        r_sh;
  logic [3:0]         st_lat;
  logic [3:0]         g_tens, g_ones, r_tens, r_ones, st_disp;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;
  logic [2:0]         idx;
  logic               scan_wrap;
  logic [2:0]         next_idx;
  logic [7:0]         digit_seg;

  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  // Shift register layout is {tens, ones, binary}; counts are at most 99 so no hundreds nibble.
  function automatic logic [14:0] dd_step(input logic [14:0] v);
    logic [14:0] t;
    t = v;
    if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7]  + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign ctl.busy = (state != S_IDLE);

  // A load in any state (re)starts conversion; COMMIT still publishes the finished result first.
  always_ff @(posedge clk) begin
    if (off_r) begin
      state   <= S_IDLE;
      iter    <= 3'd0;
      g_sh    <= 15'd0;
      r_sh    <= 15'd0;
      st_lat  <= 4'd0;
      g_tens  <= 4'd0;
      g_ones  <= 4'd0;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
      st_disp <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctl.load) state <= S_CONV;
        end
        S_CONV: begin
          g_sh <= dd_step(g_sh);
          r_sh <= dd_step(r_sh);
          iter <= iter + 3'd1;
          if (iter == 3'd6 && !ctl.load) state <= S_COMMIT;
        end
        S_COMMIT: begin
          g_tens  <= g_sh[14:11];
          g_ones  <= g_sh[10:7];
          r_tens  <= r_sh[14:11];
          r_ones  <= r_sh[10:7];
          st_disp <= st_lat;
          state   <= ctl.load ? S_CONV : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (ctl.load) begin
        g_sh   <= {8'd0, clamp99(ctl.cnt_g)};
        r_sh   <= {8'd0, clamp99(ctl.cnt_r)};
        st_lat <= ctl.state_in;
        iter   <= 3'd0;
      end
    end
  end

  assign scan_wrap = (scan_cnt == SCAN_LAST);
  assign next_idx  = scan_wrap ? idx + 3'd1 : idx;

  // Pins are driven from the index being entered so AN and SIG_C move together on the wrap edge.
  always_comb begin
    digit_seg = 8'hFF;
    case (next_idx)
      3'd0: digit_seg = seg_code(r_ones);
      3'd1: digit_seg = (r_tens == 4'd0) ? 8'hFF : seg_code(r_tens);
      3'd2: digit_seg = seg_code(g_ones);
      3'd3: digit_seg = (g_tens == 4'd0) ? 8'hFF : seg_code(g_tens);
      3'd4: digit_seg = seg_code(st_disp);
      default: digit_seg = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (off_r) begin
      scan_cnt  <= '0;
      idx       <= 3'd0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      AN        <= 8'hFF;
      SIG_C     <= 8'hFF;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      idx      <= next_idx;
      if (!blink) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
      if (blink && phase) begin
        AN    <= 8'hFF;
        SIG_C <= 8'hFF;
      end else begin
        AN    <= ~(8'd1 << next_idx);
        SIG_C <= digit_seg;
      end
    end
  end

endmodule

// File: tb/tb_light_display.sv
// Scoreboard bench for light_display: expected frames are queued when a load is
// driven and popped as the scan walks digits 0..7.
module tb_light_display;

  localparam int SD = 4;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       off_r;
  logic       blink;
  logic [7:0] SIG_C;
  logic [7:0] AN;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q [$];
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  light_display_if bus ();

  light_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk   (clk),
    .off_r (off_r),
    .ctl   (bus.slave),
    .blink (blink),
    .SIG_C (SIG_C),
    .AN    (AN)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_code(input int i, input int g, input int r, input int s);
    int gc, rc;
    gc = (g > 99) ? 99 : g;
    rc = (r > 99) ? 99 : r;
    case (i)
      0: return seg_tab[rc % 10];
      1: return (rc / 10 == 0) ? 8'hFF : seg_tab[rc / 10];
      2: return seg_tab[gc % 10];
      3: return (gc / 10 == 0) ? 8'hFF : seg_tab[gc / 10];
      4: return seg_tab[s & 15];
      default: return 8'hFF;
    endcase
  endfunction

  task automatic push_frame(input int g, input int r, input int s);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] an_e;
      an_e = ~(8'd1 << i);
      exp_q.push_back({an_e, exp_code(i, g, r, s)});
    end
  endtask

  task automatic do_load(input int g, input int r, input int s);
    bus.cnt_g    = 7'(g);
    bus.cnt_r    = 7'(r);
    bus.state_in = 4'(s);
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  // Align to the start of a frame, then pop one expected digit per scan slot.
  task automatic check_frame(input string name);
    logic [7:0] prev;
    int guard;
    logic [15:0] e;
    guard = 0;
    prev = AN;
    tick();
    while (!(AN == 8'hFE && prev != 8'hFE) && guard < 100) begin
      prev = AN;
      tick();
      guard++;
    end
    if (guard >= 100) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s frame_start: AN=%h never began a frame", name, AN);
      repeat (8) if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if ({AN, SIG_C} !== e) begin
        miscompares++;
        $display("[TB] FAIL %s digit%0d: got AN=%h SIG_C=%h want AN=%h SIG_C=%h",
                 name, i, AN, SIG_C, e[15:8], e[7:0]);
      end
      if (i < 7) repeat (SD) tick();
    end
  endtask

  task automatic count_busy(input string name, input int want);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    vectors++;
    if (n != want) begin
      miscompares++;
      $display("[TB] FAIL %s busy_len: got %0d want %0d", name, n, want);
    end
  endtask

  task automatic test_reset;
    logic [7:0] an_seq [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    off_r = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({AN, SIG_C, bus.busy} !== {8'hFF, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got AN=%h SIG_C=%h busy=%b want FF FF 0", AN, SIG_C, bus.busy);
    end
    push_frame(0, 0, 0);
    off_r = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (AN !== an_seq[k]) begin
        miscompares++;
        $display("[TB] FAIL reset_scan step%0d: got AN=%h want %h", k, AN, an_seq[k]);
      end
      repeat ((k == 0) ? SD - 1 : SD) tick();
    end
    check_frame("reset_frame");
  endtask

  task automatic test_load_convert;
    push_frame(57, 8, 10);
    do_load(57, 8, 10);
    count_busy("load_convert", 8);
    check_frame("load_convert");
  endtask

  task automatic test_clamp_zero;
    push_frame(120, 0, 3);
    do_load(120, 0, 3);
    count_busy("clamp_zero", 8);
    check_frame("clamp_zero");
  endtask

  task automatic test_restart;
    int bad;
    bad = 0;
    do_load(57, 8, 1);
    tick();
    tick();
    push_frame(23, 45, 7);
    do_load(23, 45, 7);
    for (int k = 0; k < 48; k++) begin
      if (AN == 8'hF7 && SIG_C == 8'h92) bad++;
      if (AN == 8'hFE && SIG_C == 8'h80) bad++;
      if (k == 0) begin
        count_busy("restart", 8);
      end else begin
        tick();
      end
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL restart_no57: got %0d stale samples want 0", bad);
    end
    check_frame("restart");
  endtask

  task automatic test_back_to_back;
    int n;
    int ai;
    n = 0;
    do_load(11, 22, 5);
    repeat (7) tick();
    do_load(33, 44, 6);
    if (bus.busy === 1'b1) n++;
    tick();
    ai = -1;
    for (int i = 0; i < 8; i++) if (AN[i] == 1'b0) ai = i;
    vectors++;
    if (ai < 0 || SIG_C !== exp_code(ai, 11, 22, 5)) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_commit: got AN=%h SIG_C=%h want digit of 11/22/5",
               AN, SIG_C);
    end
    if (bus.busy === 1'b1) n++;
    tick();
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_busy: got %0d want 8", n);
    end
    push_frame(33, 44, 6);
    check_frame("back_to_back");
  endtask

  task automatic test_blink;
    logic dark_e;
    blink = 1'b1;
    for (int k = 0; k < 64; k++) begin
      tick();
      dark_e = ((k / BD) % 2) == 1;
      vectors++;
      if ((AN == 8'hFF) !== dark_e) begin
        miscompares++;
        $display("[TB] FAIL blink cycle%0d: got AN=%h want dark=%b", k, AN, dark_e);
      end
      if (dark_e && SIG_C !== 8'hFF) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL blink_seg cycle%0d: got SIG_C=%h want FF", k, SIG_C);
      end
    end
    blink = 1'b0;
    tick();
    vectors++;
    if (AN === 8'hFF) begin
      miscompares++;
      $display("[TB] FAIL blink_release: got AN=%h want a lit digit", AN);
    end
  endtask

  task automatic test_reset_mid_conv;
    int seen;
    seen = 0;
    off_r = 1'b1;
    tick();
    off_r = 1'b0;
    do_load(57, 8, 2);
    repeat (3) tick();
    off_r = 1'b1;
    tick();
    vectors++;
    if ({AN, bus.busy} !== {8'hFF, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got AN=%h busy=%b want FF 0", AN, bus.busy);
    end
    off_r = 1'b0;
    push_frame(0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.busy !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_busy: got %0d busy cycles want 0", seen);
    end
    check_frame("mid_reset");
  endtask

  initial begin
    off_r        = 1'b1;
    blink        = 1'b0;
    bus.load     = 1'b0;
    bus.cnt_g    = 7'd0;
    bus.cnt_r    = 7'd0;
    bus.state_in = 4'd0;
    test_reset();
    test_load_convert();
    test_clamp_zero();
    test_restart();
    test_back_to_back();
    test_blink();
    test_reset_mid_conv();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
